// File: rtl/html_char_source_if.sv
// Stream, control and buffer-write signals of html_char_source.
// The slave modport is the block's view; the master modport is the driver's view.
interface html_char_source_if #(
  parameter int CHAR_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);
  logic                  state_enable;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [CHAR_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH:0]   length;
  logic                  out_ready;
  logic [CHAR_WIDTH-1:0] char;
  logic                  char_valid;
  logic                  has_finished;
  logic [ADDR_WIDTH:0]   index;

  modport slave (
    input  state_enable, wr_en, wr_addr, wr_data, length, out_ready,
    output char, char_valid, has_finished, index
  );

  modport master (
    output state_enable, wr_en, wr_addr, wr_data, length, out_ready,
    input  char, char_valid, has_finished, index
  );
endinterface

// File: rtl/html_char_source.sv
// Loadable character buffer streamed out over valid/ready until a NUL or the
// programmed length is reached; feeds the HTML tokenizer's reading stage.
module html_char_source #(
  parameter int CHAR_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6
) (
  input logic               clock,
  input logic               resetn,
  html_char_source_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    CHECK  = 3'd2,
    STREAM = 3'd3,
    DONE   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   index_q, index_d;
  logic [CHAR_WIDTH-1:0] char_q, char_d;
  logic                  valid_q, valid_d;
  logic                  fin_q, fin_d;
  logic [CHAR_WIDTH-1:0] rd_data_q;
  logic [CHAR_WIDTH-1:0] mem_q [DEPTH];
  logic                  rd_en_s;
  logic [ADDR_WIDTH-1:0] rd_addr_s;

  // Buffer: write port plus registered read; nonblocking update gives read-first.
  always_ff @(posedge clock) begin
    if (bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_W)) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
    if (rd_en_s) begin
      rd_data_q <= mem_q[rd_addr_s];
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      len_q   <= {(ADDR_WIDTH+1){1'b0}};
      index_q <= {(ADDR_WIDTH+1){1'b0}};
      char_q  <= {CHAR_WIDTH{1'b0}};
      valid_q <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      index_q <= index_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      fin_q   <= fin_d;
    end
  end

  // Next state and outputs; dropping state_enable overrides every transition.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    index_d   = index_q;
    char_d    = char_q;
    valid_d   = valid_q;
    fin_d     = fin_q;
    rd_en_s   = 1'b0;
    rd_addr_s = index_q[ADDR_WIDTH-1:0];
    if (!bus.state_enable) begin
      state_d = IDLE;
      index_d = {(ADDR_WIDTH+1){1'b0}};
      char_d  = {CHAR_WIDTH{1'b0}};
      valid_d = 1'b0;
      fin_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          len_d   = (bus.length > DEPTH_W) ? DEPTH_W : bus.length;
          index_d = {(ADDR_WIDTH+1){1'b0}};
          char_d  = {CHAR_WIDTH{1'b0}};
          valid_d = 1'b0;
          fin_d   = 1'b0;
          state_d = FETCH;
        end
        FETCH: begin
          if (index_q == len_q) begin
            fin_d   = 1'b1;
            state_d = DONE;
          end else begin
            rd_en_s = 1'b1;
            state_d = CHECK;
          end
        end
        CHECK: begin
          // A NUL terminates the stream without ever being presented.
          if (rd_data_q == {CHAR_WIDTH{1'b0}}) begin
            fin_d   = 1'b1;
            state_d = DONE;
          end else begin
            char_d  = rd_data_q;
            valid_d = 1'b1;
            state_d = STREAM;
          end
        end
        STREAM: begin
          if (bus.out_ready) begin
            char_d  = {CHAR_WIDTH{1'b0}};
            valid_d = 1'b0;
            index_d = index_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
            state_d = FETCH;
          end else begin
            char_d  = char_q;
            valid_d = 1'b1;
            state_d = STREAM;
          end
        end
        DONE: begin
          char_d  = {CHAR_WIDTH{1'b0}};
          valid_d = 1'b0;
          fin_d   = 1'b1;
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
          index_d = {(ADDR_WIDTH+1){1'b0}};
          char_d  = {CHAR_WIDTH{1'b0}};
          valid_d = 1'b0;
          fin_d   = 1'b0;
        end
      endcase
    end
  end

  assign bus.char         = char_q;
  assign bus.char_valid   = valid_q;
  assign bus.has_finished = fin_q;
  assign bus.index        = index_q;
endmodule

// File: tb/tb_html_char_source.sv
// Directed bench for html_char_source: load strings, stream them, and compare
// characters, latencies and finish cycles against hand-computed values.
module tb_html_char_source;
  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  html_char_source_if #(.CHAR_WIDTH(8), .ADDR_WIDTH(6)) bus ();

  html_char_source #(.CHAR_WIDTH(8), .DEPTH(64), .ADDR_WIDTH(6)) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus.slave)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] got_q[$];
  int         first_valid;
  int         fin_cyc;
  int         held_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int addr, input logic [7:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 6'(addr);
    bus.wr_data = data;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic idle();
    bus.state_enable = 1'b0;
    step();
  endtask

  // Cycle c is sampled just after the c-th edge following entry (c=0 is E0).
  task automatic collect(input int max_cyc);
    got_q.delete();
    first_valid = -1;
    fin_cyc     = -1;
    for (int c = 0; c < max_cyc; c++) begin
      step();
      if (bus.char_valid) begin
        if (first_valid < 0) first_valid = c;
        if (bus.out_ready) got_q.push_back(bus.char);
      end
      if (bus.has_finished) begin
        fin_cyc = c;
        break;
      end
    end
    chk("finish_seen", 32'(fin_cyc >= 0), 32'd1);
  endtask

  initial begin
    resetn           = 1'b0;
    bus.state_enable = 1'b0;
    bus.wr_en        = 1'b0;
    bus.wr_addr      = 6'd0;
    bus.wr_data      = 8'd0;
    bus.length       = 7'd0;
    bus.out_ready    = 1'b0;
    step();
    step();
    chk("rst_char",  32'(bus.char), 32'd0);
    chk("rst_valid", 32'(bus.char_valid), 32'd0);
    chk("rst_fin",   32'(bus.has_finished), 32'd0);
    chk("rst_index", 32'(bus.index), 32'd0);
    resetn = 1'b1;

    wr(0, 8'h3C); wr(1, 8'h70); wr(2, 8'h3E); wr(3, 8'h78);

    // "<p>x", length 4, consumer always ready
    bus.length = 7'd4; bus.out_ready = 1'b1; bus.state_enable = 1'b1;
    collect(40);
    chk("a_first", 32'(first_valid), 32'd2);
    chk("a_count", 32'(got_q.size()), 32'd4);
    chk("a_c0", 32'(got_q[0]), 32'h3C);
    chk("a_c1", 32'(got_q[1]), 32'h70);
    chk("a_c2", 32'(got_q[2]), 32'h3E);
    chk("a_c3", 32'(got_q[3]), 32'h78);
    chk("a_fin_cyc", 32'(fin_cyc), 32'd13);
    chk("a_index", 32'(bus.index), 32'd4);
    step();
    chk("a_sticky", 32'(bus.has_finished), 32'd1);
    idle();
    chk("a_clear_fin", 32'(bus.has_finished), 32'd0);
    chk("a_clear_idx", 32'(bus.index), 32'd0);

    // backpressure on the first character
    bus.out_ready = 1'b0; bus.state_enable = 1'b1;
    step(); step(); step();
    chk("bp_valid", 32'(bus.char_valid), 32'd1);
    chk("bp_char",  32'(bus.char), 32'h3C);
    held_bad = 0;
    repeat (5) begin
      step();
      if (!(bus.char_valid === 1'b1 && bus.char === 8'h3C && bus.index === 7'd0)) held_bad++;
    end
    chk("bp_hold", 32'(held_bad), 32'd0);
    bus.out_ready = 1'b1;
    step();
    chk("bp_acc_valid", 32'(bus.char_valid), 32'd0);
    chk("bp_acc_index", 32'(bus.index), 32'd1);
    collect(40);
    chk("bp_count", 32'(got_q.size()), 32'd3);
    chk("bp_c1", 32'(got_q[0]), 32'h70);
    chk("bp_c3", 32'(got_q[2]), 32'h78);
    idle();

    // state_enable drop while the second character is pending
    bus.out_ready = 1'b1; bus.state_enable = 1'b1;
    repeat (6) step();
    chk("drop_pre_char",  32'(bus.char), 32'h70);
    chk("drop_pre_index", 32'(bus.index), 32'd1);
    bus.state_enable = 1'b0;
    step();
    chk("drop_char",  32'(bus.char), 32'd0);
    chk("drop_valid", 32'(bus.char_valid), 32'd0);
    chk("drop_index", 32'(bus.index), 32'd0);
    bus.state_enable = 1'b1;
    collect(40);
    chk("drop_re_first", 32'(first_valid), 32'd2);
    chk("drop_re_count", 32'(got_q.size()), 32'd4);
    chk("drop_re_c0", 32'(got_q[0]), 32'h3C);
    idle();

    // reset while in CHECK, enable still high
    bus.state_enable = 1'b1;
    step(); step();
    resetn = 1'b0;
    step();
    chk("mrst_char",  32'(bus.char), 32'd0);
    chk("mrst_valid", 32'(bus.char_valid), 32'd0);
    chk("mrst_fin",   32'(bus.has_finished), 32'd0);
    chk("mrst_index", 32'(bus.index), 32'd0);
    resetn = 1'b1;
    collect(40);
    chk("mrst_first", 32'(first_valid), 32'd2);
    chk("mrst_count", 32'(got_q.size()), 32'd4);
    chk("mrst_c1", 32'(got_q[1]), 32'h70);
    chk("mrst_c3", 32'(got_q[3]), 32'h78);
    idle();

    // NUL terminator before the programmed length
    wr(0, 8'h61); wr(1, 8'h62); wr(2, 8'h00);
    bus.length = 7'd10; bus.state_enable = 1'b1;
    collect(40);
    chk("nul_count", 32'(got_q.size()), 32'd2);
    chk("nul_c0", 32'(got_q[0]), 32'h61);
    chk("nul_c1", 32'(got_q[1]), 32'h62);
    chk("nul_fin_cyc", 32'(fin_cyc), 32'd8);
    chk("nul_index", 32'(bus.index), 32'd2);
    idle();

    // zero length
    bus.length = 7'd0; bus.state_enable = 1'b1;
    collect(10);
    chk("len0_count", 32'(got_q.size()), 32'd0);
    chk("len0_first", 32'(first_valid), 32'hFFFF_FFFF);
    chk("len0_fin_cyc", 32'(fin_cyc), 32'd1);
    idle();

    // full buffer, length clamped from 100 to 64
    for (int i = 0; i < 64; i++) wr(i, 8'(i + 1));
    bus.length = 7'd100; bus.state_enable = 1'b1;
    collect(400);
    chk("full_count", 32'(got_q.size()), 32'd64);
    chk("full_c0",  32'(got_q[0]), 32'd1);
    chk("full_c63", 32'(got_q[63]), 32'd64);
    chk("full_fin_cyc", 32'(fin_cyc), 32'd193);
    chk("full_index", 32'(bus.index), 32'd64);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
